// File: rtl/regfile_loader_ctrl.sv
// Register-file loader: streams words into registers 0..LOAD_COUNT-1,
// optionally clears them, or hands the file to the CPU (RUN).
// Ports: clk, reset (async, active-high); commands start_load,
//   start_clear, run, halt; stream load_data/load_valid/load_ready;
//   MAU port mau_clk_en/mau_address/mau_data_write/mau_wren;
//   status alive, busy, done.
// Build macro REGFILE_CLEAR_EN enables the CLEAR state and start_clear.
module regfile_loader_ctrl #(
  parameter int LOAD_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_load,
  input  logic        start_clear,
  input  logic        run,
  input  logic        halt,
  input  logic [31:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        mau_clk_en,
  output logic [31:0] mau_address,
  output logic [31:0] mau_data_write,
  output logic        mau_wren,
  output logic        alive,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LastIdx = 5'(LOAD_COUNT - 1);

`ifdef REGFILE_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    RUN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd3
  } state_t;
`endif

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  idx_q;
  logic [4:0]  idx_d;
  logic        wr_q;
  logic        wr_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        done_q;
  logic        done_d;
  logic        alive_q;
  logic        alive_d;

`ifndef REGFILE_CLEAR_EN
  logic unused_start_clear;
  assign unused_start_clear = start_clear;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef REGFILE_CLEAR_EN
        if (start_clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else
`endif
        if (start_load) begin
          state_d = LOAD;
          idx_d   = '0;
        end else if (run) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (halt) begin
          state_d = IDLE;
        end else if (load_valid) begin
          wr_d   = 1'b1;
          addr_d = {25'b0, idx_q, 2'b00};
          data_d = load_data;
          // Hold the index on the last word so it never wraps.
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef REGFILE_CLEAR_EN
      CLEAR: begin
        if (halt) begin
          state_d = IDLE;
        end else begin
          wr_d   = 1'b1;
          addr_d = {25'b0, idx_q, 2'b00};
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`endif
      RUN: begin
        if (halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    alive_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      alive_q <= alive_d;
    end
  end

  assign load_ready     = (state_q == LOAD) && !halt;
  assign mau_clk_en     = wr_q;
  assign mau_wren       = wr_q;
  assign mau_address    = addr_q;
  assign mau_data_write = data_q;
  assign done           = done_q;
  assign alive          = alive_q;
`ifdef REGFILE_CLEAR_EN
  assign busy = (state_q == LOAD) || (state_q == CLEAR);
`else
  assign busy = (state_q == LOAD);
`endif

endmodule

// File: tb/tb_regfile_loader_ctrl.sv
// Scoreboard bench for regfile_loader_ctrl: stimulus pushes expected
// writes, a monitor pops and compares on every MAU write.
module tb_regfile_loader_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load;
  logic        start_clear;
  logic        run;
  logic        halt;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        mau_clk_en;
  logic [31:0] mau_address;
  logic [31:0] mau_data_write;
  logic        mau_wren;
  logic        alive;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  checks = 0;
  int  failures = 0;

  regfile_loader_ctrl #(.LOAD_COUNT(N)) dut (
    .clk(clk),
    .reset(rst),
    .start_load(start_load),
    .start_clear(start_clear),
    .run(run),
    .halt(halt),
    .load_data(load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .mau_clk_en(mau_clk_en),
    .mau_address(mau_address),
    .mau_data_write(mau_data_write),
    .mau_wren(mau_wren),
    .alive(alive),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic logic [31:0] all_outs();
    return {24'b0, alive, busy, done, load_ready, mau_wren,
            mau_clk_en, |mau_address, |mau_data_write};
  endfunction

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("outs_in_reset", all_outs(), 32'h0);
    end else begin
      chk("clk_en_eq_wren", {31'b0, mau_clk_en}, {31'b0, mau_wren});
      if (mau_wren) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h",
                   mau_address, mau_data_write);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mau_address, e.addr);
          chk("wr_data", mau_data_write, e.data);
          chk("wr_done", {31'b0, done}, {31'b0, e.last});
        end
      end else if (done) begin
        chk("done_without_write", {31'b0, done}, 32'h0);
      end
      if (alive)
        chk("run_mau_quiet",
            {28'b0, mau_wren, mau_clk_en, |mau_address,
             |mau_data_write}, 32'h0);
    end
  end

  task automatic drain(string nm);
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // mode 0: valid every cycle; 1: 3-cycle gap after word 5;
  // 2: random gaps. stop_at >= 0 aborts after that many handshakes.
  task automatic do_load(input int mode, input int stop_at,
                         input bit use_reset);
    int sent = 0;
    int gaps = 0;
    bit v;
    logic [31:0] w;
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    chk("load_busy", {31'b0, busy}, 32'h1);
    while (sent < N) begin
      if (sent == stop_at) break;
      chk("load_ready_in_load", {31'b0, load_ready}, 32'h1);
      v = 1'b1;
      if (mode == 1 && sent == 6 && gaps < 3) begin
        v = 1'b0;
        gaps++;
      end else if (mode == 2) begin
        v = ($urandom_range(0, 3) != 0);
      end
      w = (mode == 0) ? 32'hA000_0000 + sent : $urandom;
      load_valid = v;
      load_data = w;
      if (v) begin
        exp_q.push_back('{addr: sent * 4, data: w,
                          last: (sent == N - 1)});
        sent++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    if (sent == N) begin
      chk("done_pulse", {31'b0, done}, 32'h1);
      chk("idle_after_load", {31'b0, busy}, 32'h0);
    end else if (use_reset) begin
      rst = 1'b1;
      #1;
      chk("reset_mid_load", all_outs(), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {30'b0, busy, alive}, 32'h0);
    end else begin
      halt = 1'b1;
      load_valid = 1'b1;
      load_data = $urandom;
      #1;
      chk("ready_low_on_halt", {31'b0, load_ready}, 32'h0);
      @(negedge clk);
      halt = 1'b0;
      load_valid = 1'b0;
      chk("idle_after_halt", {29'b0, busy, done, load_ready}, 32'h0);
    end
    drain("load_queue_empty");
  endtask

  task automatic clear_test();
    int cnt = 0;
    @(negedge clk);
    start_clear = 1'b1;
`ifdef REGFILE_CLEAR_EN
    for (int i = 0; i < N; i++)
      exp_q.push_back('{addr: i * 4, data: 32'h0, last: (i == N - 1)});
`endif
    @(negedge clk);
    start_clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
`ifdef REGFILE_CLEAR_EN
    chk("clear_busy_cycles", cnt, N);
`else
    chk("clear_ignored", cnt, 0);
    repeat (4) @(negedge clk);
`endif
    drain("clear_queue_empty");
  endtask

  task automatic run_test();
    @(negedge clk);
    chk("alive_before_run", {31'b0, alive}, 32'h0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("alive_in_run", {30'b0, alive, busy}, 32'h2);
    repeat (3) begin
      start_load = 1'b1;
      load_valid = 1'b1;
      load_data = $urandom;
      @(negedge clk);
      chk("run_ignores_cmd", {30'b0, alive, busy}, 32'h2);
    end
    start_load = 1'b0;
    load_valid = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("alive_after_halt", {30'b0, alive, busy}, 32'h0);
    drain("run_no_writes");
  endtask

  task automatic prio_test();
    @(negedge clk);
    start_load = 1'b1;
    run = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    run = 1'b0;
    chk("load_over_run", {29'b0, busy, load_ready, alive}, 32'h6);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("prio_halted", {30'b0, busy, alive}, 32'h0);
`ifdef REGFILE_CLEAR_EN
    start_clear = 1'b1;
    start_load = 1'b1;
    run = 1'b1;
    for (int i = 0; i < N; i++)
      exp_q.push_back('{addr: i * 4, data: 32'h0, last: (i == N - 1)});
    @(negedge clk);
    start_clear = 1'b0;
    start_load = 1'b0;
    run = 1'b0;
    chk("clear_over_load", {29'b0, busy, load_ready, alive}, 32'h4);
    repeat (N) @(negedge clk);
    chk("clear_prio_done", {31'b0, busy}, 32'h0);
`endif
    drain("prio_queue_empty");
  endtask

  initial begin
    rst = 1'b1;
    start_load = 1'b0;
    start_clear = 1'b0;
    run = 1'b0;
    halt = 1'b0;
    load_data = '0;
    load_valid = 1'b0;
    #1;
    chk("reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_init", all_outs(), 32'h0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("idle_ignores_halt", {31'b0, busy}, 32'h0);
    do_load(0, -1, 1'b0);
    do_load(1, -1, 1'b0);
    repeat (3) do_load(2, -1, 1'b0);
    do_load(2, 10, 1'b0);
    do_load(0, -1, 1'b0);
    clear_test();
    run_test();
    prio_test();
    do_load(2, 12, 1'b1);
    do_load(2, -1, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
